lif_array: RTL and testbench

- Parametrised array of N leaky integrate-and-fire neurons sharing one clock and one runtime configuration.
- Each neuron integrates its own input current on a step strobe and applies a shift-based leak.
- On a threshold crossing it fires a single-cycle spike, then enters a programmable refractory period.
- Successor to the single fixed-width, always-integrating neuron. Adds width and channel generalisation, saturation, a run-time threshold, leak and refractory config, and a step enable.

---
 rtl/lif_array.sv | 85 ++++++++
 tb/tb_lif_array.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lif_array.sv
// lif_array: array of N leaky integrate-and-fire neurons with shared runtime config.
// Optional build macro LIF_SUBTRACT_RESET_EN selects reset-by-subtraction on fire
// (residue kept). Without it a firing neuron resets to zero.
module lif_array #(
    parameter int N          = 4,
    parameter int WIDTH      = 8,
    parameter int RWIDTH     = 4,
    parameter int THRESH_RST = 200,
    parameter int LEAK_RST   = 1,
    parameter int REFRAC_RST = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step,
    input  logic [N*WIDTH-1:0]   current,
    input  logic                 cfg_we,
    input  logic [WIDTH-1:0]     cfg_threshold,
    input  logic [2:0]           cfg_leak_shift,
    input  logic [RWIDTH-1:0]    cfg_refrac,
    output logic [N*WIDTH-1:0]   state,
    output logic [N-1:0]         spike,
    output logic [N-1:0]         refractory
);
    logic [WIDTH-1:0]    thr_q;
    logic [2:0]          leak_q;
    logic [RWIDTH-1:0]   refrac_q;
    logic [N*WIDTH-1:0]  state_q, state_d;
    logic [N*RWIDTH-1:0] cnt_q, cnt_d;
    logic [N-1:0]        spike_q, spike_d, refr_q, refr_d;

    for (genvar g = 0; g < N; g++) begin : g_n
        logic [WIDTH-1:0]  st, sat, fire_st;
        logic [WIDTH:0]    sum;
        logic [RWIDTH-1:0] cnt;
        logic              busy, fire;
        assign st   = state_q[g*WIDTH +: WIDTH];
        assign cnt  = cnt_q[g*RWIDTH +: RWIDTH];
        assign busy = cnt != '0;
        // A shift of WIDTH or more naturally yields zero, so no special case is needed.
        assign sum  = {1'b0, current[g*WIDTH +: WIDTH]} + {1'b0, st >> leak_q};
        assign sat  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        assign fire = !busy && sat >= thr_q;
`ifdef LIF_SUBTRACT_RESET_EN
        assign fire_st = refrac_q != '0 ? '0 : sat - thr_q;
`else
        assign fire_st = '0;
`endif
        assign state_d[g*WIDTH +: WIDTH]  = !step ? st : busy ? '0 : fire ? fire_st : sat;
        assign cnt_d[g*RWIDTH +: RWIDTH]  = !step ? cnt : busy ? cnt - RWIDTH'(1) : fire ? refrac_q : cnt;
        assign spike_d[g] = step && fire;
        assign refr_d[g]  = cnt_d[g*RWIDTH +: RWIDTH] != '0;
    end

    // Config registers: a step in the same cycle still sees the old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_q    <= WIDTH'(THRESH_RST);
            leak_q   <= 3'(LEAK_RST);
            refrac_q <= RWIDTH'(REFRAC_RST);
        end else if (cfg_we) begin
            thr_q    <= cfg_threshold;
            leak_q   <= cfg_leak_shift;
            refrac_q <= cfg_refrac;
        end
    end

    // Neuron state, refractory counters and single-cycle spike outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            cnt_q   <= '0;
            spike_q <= '0;
            refr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
            refr_q  <= refr_d;
        end
    end

    assign state      = state_q;
    assign spike      = spike_q;
    assign refractory = refr_q;
endmodule

// File: tb/tb_lif_array.sv
// tb_lif_array: directed scoreboard bench for lif_array (N=2, WIDTH=8).
module tb_lif_array;
    localparam int N = 2, W = 8, RW = 4;
    logic clk = 0, reset = 1, step = 0, cfg_we = 0;
    logic [N*W-1:0] current = '0;
    logic [W-1:0]   cfg_threshold = '0;
    logic [2:0]     cfg_leak_shift = '0;
    logic [RW-1:0]  cfg_refrac = '0;
    logic [N*W-1:0] state;
    logic [N-1:0]   spike, refractory;

    lif_array #(.N(N), .WIDTH(W), .RWIDTH(RW)) dut (
        .clk(clk), .reset(reset), .step(step), .current(current),
        .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_leak_shift(cfg_leak_shift),
        .cfg_refrac(cfg_refrac), .state(state), .spike(spike), .refractory(refractory)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*W-1:0] st;
        logic [N-1:0]   sp;
        logic [N-1:0]   rf;
    } exp_t;
    exp_t q[$];
    int errors = 0, checks = 0;
    int m_st[N], m_cnt[N];
    int m_thr = 200, m_leak = 1, m_ref = 0;
    int sub_seq[12] = '{100, 150, 175, 187, 193, 196, 198, 199, 199, 199, 199, 199};
    int crs_seq[7]  = '{101, 151, 176, 189, 195, 198, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0;
            m_cnt[i] = 0;
        end
        m_thr = 200; m_leak = 1; m_ref = 0;
        q.delete();
    endtask

    task automatic cyc(input string tag, input logic s, input int c0, input int c1,
                       input logic we = 0, input int thr = 0, input int lk = 0, input int rf = 0);
        exp_t e;
        int cur[N];
        int sum, nx;
        @(negedge clk);
        step = s; cfg_we = we;
        current = {c1[W-1:0], c0[W-1:0]};
        cfg_threshold = thr[W-1:0]; cfg_leak_shift = lk[2:0]; cfg_refrac = rf[RW-1:0];
        cur[0] = c0; cur[1] = c1;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (s) begin
                if (m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    m_st[i] = 0;
                end else begin
                    sum = cur[i] + (m_st[i] >> m_leak);
                    nx = sum > 255 ? 255 : sum;
                    if (nx >= m_thr) begin
                        e.sp[i] = 1'b1;
`ifdef LIF_SUBTRACT_RESET_EN
                        m_st[i] = m_ref > 0 ? 0 : nx - m_thr;
`else
                        m_st[i] = 0;
`endif
                        m_cnt[i] = m_ref;
                    end else m_st[i] = nx;
                end
            end
            e.st[i*W +: W] = m_st[i][W-1:0];
            e.rf[i] = m_cnt[i] != 0;
        end
        if (we) begin
            m_thr = thr; m_leak = lk; m_ref = rf;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        step = 0; cfg_we = 0;
        e = q.pop_front();
        chk({tag, ".state"}, 32'(state), 32'(e.st));
        chk({tag, ".spike"}, 32'(spike), 32'(e.sp));
        chk({tag, ".refr"}, 32'(refractory), 32'(e.rf));
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 reset = 1;
        #1;
        chk({tag, ".state"}, 32'(state), 0);
        chk({tag, ".spike"}, 32'(spike), 0);
        chk({tag, ".refr"}, 32'(refractory), 0);
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        model_reset();
        #1;
        chk("por.state", 32'(state), 0);
        chk("por.spike", 32'(spike), 0);
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 12; k++) begin
            cyc("subthr", 1, 100, 0);
            chk("subthr.seq", 32'(state[W-1:0]), 32'(sub_seq[k]));
            chk("subthr.nospike", 32'(spike[0]), 0);
        end
        cyc("idle_hold", 0, 255, 255);
        chk("idle_hold.seq", 32'(state[W-1:0]), 199);
        async_reset("rst1");
        for (int k = 0; k < 7; k++) begin
            cyc("cross", 1, 101, 0);
            chk("cross.seq", 32'(state[W-1:0]), 32'(crs_seq[k]));
            chk("cross.spike", 32'(spike), k == 6 ? 1 : 0);
            chk("cross.n1", 32'(state[2*W-1:W]), 0);
        end
        cyc("cross.after", 0, 0, 0);
        chk("cross.onecycle", 32'(spike), 0);
        cyc("collide", 1, 100, 0, 1, 50, 1, 0);
        chk("collide.nospike", 32'(spike[0]), 0);
        cyc("collide2", 1, 255, 0);
        chk("collide2.fire", 32'(spike[0]), 1);
        cyc("satcfg", 0, 0, 0, 1, 255, 1, 2);
        cyc("sat1", 1, 255, 255);
        chk("sat1.fire", 32'(spike), 3);
        cyc("refr1", 1, 255, 255);
        chk("refr1.flag", 32'(refractory), 3);
        cyc("refr2", 1, 255, 255);
        chk("refr2.state", 32'(state), 0);
        cyc("sat2", 1, 255, 255);
        chk("sat2.state", 32'(state[W-1:0]), 0);
        chk("sat2.fire", 32'(spike), 3);
        async_reset("rst2");
        cyc("mid.cfg", 0, 0, 0, 1, 200, 1, 2);
        cyc("mid.a", 1, 100, 0);
        cyc("mid.b", 1, 100, 255);
        chk("mid.state150", 32'(state[W-1:0]), 150);
        chk("mid.refr", 32'(refractory), 2);
        async_reset("rst_mid");
        cyc("dflt.a", 1, 199, 0);
        chk("dflt.nofire199", 32'(spike), 0);
        cyc("dflt.leak", 1, 0, 0);
        chk("dflt.leak1", 32'(state[W-1:0]), 99);
        cyc("dflt.fire", 1, 200, 0);
        chk("dflt.thr200", 32'(spike[0]), 1);
        cyc("dflt.refrac0", 1, 200, 0);
        chk("dflt.consec", 32'(spike[0]), 1);
        async_reset("rst3");
        cyc("sub.a", 1, 60, 0);
        cyc("sub.b", 1, 200, 0);
        chk("sub.fire", 32'(spike[0]), 1);
`ifdef LIF_SUBTRACT_RESET_EN
        chk("sub.residue", 32'(state[W-1:0]), 30);
`else
        chk("sub.zero", 32'(state[W-1:0]), 0);
`endif
        cyc("thr0.cfg", 0, 0, 0, 1, 0, 3, 0);
        cyc("thr0.a", 1, 0, 0);
        chk("thr0.a.fire", 32'(spike), 3);
        cyc("thr0.b", 1, 0, 0);
        chk("thr0.b.fire", 32'(spike), 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
